// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: streams one nibble pair per clock through a single
// 4-bit ripple-carry adder, carrying between passes through a registered carry.

module ripple_carry_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic carry;

    always_comb begin
        sum   = '0;
        carry = cin;
        for (int unsigned i = 0; i < 4; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

module nibble_serial_adder #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int unsigned NIBBLES = WIDTH / 4;
    localparam int unsigned CW = $clog2(NIBBLES);
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state, next_state;

    logic [WIDTH-1:0] a_sh, b_sh;
    logic [WIDTH-5:0] res;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             a_msb, b_msb;
    logic [3:0]       nib_sum;
    logic             nib_cout;
    logic             accept, last;

    ripple_carry_adder u_rca (
        .a    (a_sh[3:0]),
        .b    (b_sh[3:0]),
        .cin  (carry),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE: if (in_ready && in_valid) begin
                accept     = 1'b1;
                next_state = RUN;
            end
            RUN: if (cnt == LAST) begin
                last       = 1'b1;
                next_state = DONE;
            end
            DONE: if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Handshake flags track the next state so they stay registered, yet in_ready
    // is held low for the reset cycle itself.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            in_ready  <= (next_state == IDLE);
            out_valid <= (next_state == DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh     <= '0;
            b_sh     <= '0;
            res      <= '0;
            cnt      <= '0;
            carry    <= 1'b0;
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
            cnt   <= '0;
        end else if (state == RUN) begin
            // res keeps only the earlier nibbles; the last one goes straight to sum.
            res   <= (WIDTH-4)'({nib_sum, res} >> 4);
            carry <= nib_cout;
            a_sh  <= a_sh >> 4;
            b_sh  <= b_sh >> 4;
            cnt   <= cnt + 1'b1;
            if (last) begin
                sum      <= {nib_sum, res};
                cout     <= nib_cout;
                overflow <= (a_msb == b_msb) && (nib_sum[3] != a_msb);
            end
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed and random checks of nibble_serial_adder against a queued reference
// of a + b + cin with carry and signed overflow.

module tb_nibble_serial_adder;

    localparam int unsigned WIDTH   = 16;
    localparam int unsigned NIBBLES = WIDTH / 4;

    typedef struct {
        logic [WIDTH-1:0] s;
        logic             c;
        logic             o;
        int unsigned      acc_cycle;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a, b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    exp_t        sb[$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned n_done   = 0;
    int unsigned cycle    = 0;

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic c);
        exp_t m;
        logic [WIDTH:0] t;
        t = {1'b0, x} + {1'b0, y} + (WIDTH+1)'(c);
        m.s = t[WIDTH-1:0];
        m.c = t[WIDTH];
        m.o = (x[WIDTH-1] == y[WIDTH-1]) && (t[WIDTH-1] != x[WIDTH-1]);
        m.acc_cycle = 0;
        return m;
    endfunction

    // One clock: predicts accept/handoff from pre-edge values, then scores after the edge.
    task automatic step();
        logic acc, hs, ov_prev, h_c, h_o;
        logic [WIDTH-1:0] h_s;
        exp_t e;
        acc     = rst_n && in_valid && in_ready;
        hs      = rst_n && out_valid && out_ready;
        ov_prev = out_valid;
        h_s = sum; h_c = cout; h_o = overflow;
        if (acc) begin
            e = model(a, b, cin);
        end
        @(posedge clk);
        #1;
        cycle++;
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (hs) begin
                check("result_expected", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("sum", 32'(h_s), 32'(e.s));
                    check("cout", 32'(h_c), 32'(e.c));
                    check("overflow", 32'(h_o), 32'(e.o));
                    n_done++;
                end
            end
            if (!ov_prev && out_valid) begin
                check("valid_has_txn", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0)
                    check("latency", cycle - sb[0].acc_cycle, NIBBLES);
            end
            if (acc) begin
                e = model(a, b, cin);
                e.acc_cycle = cycle;
                sb.push_back(e);
            end
        end
    endtask

    task automatic wait_valid();
        int unsigned k = 0;
        while (!out_valid && k < 20) begin
            step();
            k++;
        end
        check("out_valid_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic run_txn(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                           input logic tc, input logic [WIDTH-1:0] es,
                           input logic ec, input logic eo);
        int unsigned k = 0;
        while (!in_ready && k < 20) begin
            step();
            k++;
        end
        check("in_ready_timeout", 32'(in_ready), 32'd1);
        a = ta; b = tb; cin = tc; in_valid = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        a = '1; b = '1; cin = 1'b1;
        wait_valid();
        check("dir_sum", 32'(sum), 32'(es));
        check("dir_cout", 32'(cout), 32'(ec));
        check("dir_overflow", 32'(overflow), 32'(eo));
        step();
        check("in_ready_after_handoff", 32'(in_ready), 32'd1);
        check("out_valid_after_handoff", 32'(out_valid), 32'd0);
    endtask

    initial begin
        int unsigned base, accepted, cyc;
        logic pre;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        step();
        step();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        step();
        check("in_ready_after_reset", 32'(in_ready), 32'd1);

        run_txn(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        run_txn(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_txn(16'h00FF, 16'h0F00, 1'b1, 16'h1000, 1'b0, 1'b0);
        run_txn(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_txn(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

        // Backpressure while DONE
        a = 16'h0001; b = 16'h0002; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        wait_valid();
        a = 16'hAAAA; b = 16'h5555; cin = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_sum", 32'(sum), 32'h0003);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        step();
        check("bp_in_ready_after_handoff", 32'(in_ready), 32'd1);
        step();
        check("bp_new_taken", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        wait_valid();
        check("bp_new_sum", 32'(sum), 32'hFFFF);
        step();

        // Reset during RUN
        a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_sum", 32'(sum), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        step();
        check("midrst_in_ready_back", 32'(in_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            step();
            check("midrst_no_output", 32'(out_valid), 32'd0);
        end
        run_txn(16'h0005, 16'h0003, 1'b0, 16'h0008, 1'b0, 1'b0);

        // Random back-to-back with random out_ready
        base = n_done; accepted = 0; cyc = 0;
        while ((n_done - base) < 200 && cyc < 10000) begin
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
            cin = 1'($urandom_range(0, 1));
            in_valid = (accepted < 200);
            out_ready = 1'($urandom_range(0, 1));
            pre = in_valid && in_ready;
            step();
            if (pre) accepted++;
            cyc++;
        end
        in_valid = 1'b0;
        check("rand_completed", n_done - base, 32'd200);
        check("rand_accepted", accepted, 32'd200);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
Multi-cycle WIDTH-bit adder. It splits the operands into 4-bit nibbles and feeds one nibble pair per clock into a single instance of the team's 4-bit ripple_carry_adder, carrying between nibbles through a registered carry. It sits upstream of that adder as its operand sequencer and downstream as the collector of its sum and carry outputs. It trades latency for area and uses valid/ready handshakes on both sides.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 8.
NIBBLES, WIDTH/4, derived localparam, not overridable; number of adder passes.

Ports:
clk  input  1  rising-edge clock; the only clock.
rst_n  input  1  synchronous active-low reset, sampled on rising clk.
in_valid  input  1  operands a, b, cin are valid.
in_ready  output  1  block can accept operands.
a  input  WIDTH  operand A (unsigned, or two's complement for overflow).
b  input  WIDTH  operand B.
cin  input  1  carry into bit 0.
out_valid  output  1  result is valid.
out_ready  input  1  consumer accepts the result.
sum  output  WIDTH  a + b + cin, modulo 2^WIDTH.
cout  output  1  carry out of bit WIDTH-1.
overflow  output  1  signed overflow: (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]).

Behaviour:
- Reset (rst_n low at a clk edge, in any state):
  - State goes to IDLE; nibble counter = 0; carry register = 0.
  - Outputs: in_ready=0, out_valid=0, sum=0, cout=0, overflow=0.
  - Any in-flight operation is discarded with no partial output.
- in_ready is a registered output.
  - It rises on the first edge with rst_n high.
  - It is 1 only in IDLE.
- FSM states:
  - IDLE: in_ready=1. On an edge with in_valid && in_ready:
    - Capture a, b into shift registers.
    - Load carry register with cin; latch a[MSB] and b[MSB].
    - Clear counter; in_ready <= 0; go to RUN.
  - RUN: each cycle the adder sees the low nibble of the A/B shift registers and the carry register. On each edge:
    - Sum nibble shifts in from the top of the result register.
    - Carry register <= adder carry.
    - A/B shift right by 4; counter increments.
    - When counter == NIBBLES-1 at an edge: go to DONE; drive sum from the completed result; cout <= final carry; overflow computed; out_valid <= 1.
  - DONE: out_valid=1; sum/cout/overflow held stable.
    - On an edge with out_ready: out_valid <= 0, in_ready <= 1, go to IDLE.
    - A new operand cannot be accepted in the same cycle as result handoff.
- Latency:
  - Operands accepted at edge E0 → out_valid is high after edge E0+NIBBLES (4 cycles for WIDTH=16).
  - Minimum issue interval is NIBBLES+2 cycles.
- in_valid outside IDLE is ignored. a, b, cin changes after capture have no effect.
- out_ready while out_valid=0 is ignored.
- Arithmetic:
  - Pure modulo-2^WIDTH addition, with the carry chain exclusively through the 4-bit adder instance.
  - No combinational path from any input to any output (in_ready and out_valid are state-derived registers).
- Result outputs are registered and change only on entry to DONE or on reset.

Test Plan:
1. WIDTH=16, a=0x1234, b=0x4321, cin=0, out_ready=1 → out_valid exactly 4 cycles after accept; sum=0x5555, cout=0, overflow=0; in_ready back to 1 one cycle after handoff.
2. a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, overflow=0. Then a=0x00FF, b=0x0F00, cin=1 → sum=0x1000, cout=0 (exercises inter-nibble carry ripple).
3. a=0x7FFF, b=0x0001 → sum=0x8000, cout=0, overflow=1. Then a=0x8000, b=0x8000 → sum=0x0000, cout=1, overflow=1.
4. Backpressure: complete 0x0001+0x0002 and hold out_ready=0 for 6 cycles while driving in_valid=1 with a=0xAAAA → out_valid stays 1, sum stays 0x0003, in_ready stays 0, new data not taken. Raise out_ready → handoff, then 0xAAAA is accepted on the next IDLE cycle.
5. Reset mid-operation: accept 0x1111+0x2222, pull rst_n low for 1 cycle during RUN (2nd nibble) → next cycle out_valid=0, sum=0, in_ready=0; in_ready=1 one cycle after rst_n high; a fresh 0x0005+0x0003 yields 0x0008.
6. Back-to-back: random a/b/cin for 200 transactions, with in_valid always 1 and out_ready randomly toggled → every result matches the reference a+b+cin (sum, cout, overflow), no lost or duplicated transactions, latency always NIBBLES.
